// File: rtl/display_scan_mux.sv
// Time-multiplexed 4-digit 7-segment scanner with per-frame snapshot, anode blanking and colon drive.
// Latency: seg/an/colon are registered, reflecting idx, cnt and display_en one cycle earlier.
// Backpressure: none; free-running scan. Optional macro COLON_BLINK_EN toggles the colon on sec_tick.
module display_scan_mux #(
   parameter int REFRESH_DIV    = 16,
   parameter int BLANK_CYCLES   = 1,
   parameter bit SEG_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sec_tick,
   input  logic       display_en,
   input  logic [6:0] minuteDisp1,
   input  logic [6:0] minuteDisp2,
   input  logic [6:0] hourDisp1,
   input  logic [6:0] hourDisp2,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       colon
);

   localparam int              CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]   CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]   CNT_BLANK = CW'(BLANK_CYCLES);
   localparam logic [6:0]      SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0][6:0] snap_q;
   logic            first_q;
   logic            slot_end, frame_end, capture, lit;
   logic [6:0]      seg_code, seg_d;
   logic [3:0]      an_d;
   logic            colon_d;

   // Scan timing: slot counter and digit index
   always_comb begin
      slot_end  = (cnt_q == CNT_LAST);
      frame_end = slot_end && (idx_q == 2'd3);
      cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
      idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
   end

   // first_q forces one capture on the first edge after reset so the display never shows zeros for a frame
   assign capture = first_q | frame_end;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         first_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         first_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         snap_q <= '0;
      end else if (capture) begin
         snap_q <= {hourDisp2, hourDisp1, minuteDisp2, minuteDisp1};
      end
   end

   // Output decode: lit only past the ghost-suppression window; one-hot-low an by construction
   always_comb begin
      lit      = display_en && (cnt_q >= CNT_BLANK);
      seg_code = snap_q[idx_q];
      seg_d    = SEG_BLANK;
      an_d     = 4'b1111;
      if (lit) begin
         seg_d = SEG_ACTIVE_LOW ? ~seg_code : seg_code;
         an_d  = ~(4'b0001 << idx_q);
      end
   end

`ifdef COLON_BLINK_EN
   logic blink_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_q <= 1'b0;
      end else if (sec_tick && display_en) begin
         blink_q <= ~blink_q;
      end
   end

   assign colon_d = display_en & blink_q;
`else
   logic unused_sec_tick;

   assign unused_sec_tick = sec_tick;
   assign colon_d         = display_en;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg   <= SEG_BLANK;
         an    <= 4'b1111;
         colon <= 1'b0;
      end else begin
         seg   <= seg_d;
         an    <= an_d;
         colon <= colon_d;
      end
   end

endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
- REQ-001 SHALL have parameter REFRESH_DIV, default 16: clock cycles each digit slot lasts; legal range 2..65535.
- REQ-002 SHALL have parameter BLANK_CYCLES, default 1: anode-off cycles at the start of each slot for ghost suppression; legal range 0..REFRESH_DIV-1.
- REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 means seg is driven as the bitwise inverse of the segment code.
- REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
- REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
- REQ-006 SHALL have port sec_tick, input, 1 bit: one-cycle pulse, once per second.
- REQ-007 SHALL have port display_en, input, 1 bit: 0 blanks all digits and the colon.
- REQ-008 SHALL have ports minuteDisp1, minuteDisp2, hourDisp1, hourDisp2, input, 7 bits each: active-high segment codes.
- REQ-009 SHALL have port seg, output, 7 bits: shared segment bus.
- REQ-010 SHALL have port an, output, 4 bits: active-low digit enables. an[0]=minuteDisp1, an[1]=minuteDisp2, an[2]=hourDisp1, an[3]=hourDisp2.
- REQ-011 SHALL have port colon, output, 1 bit: active-high colon LED.

Function
- REQ-012 SHALL keep a slot counter cnt (0..REFRESH_DIV-1) and a digit index idx (0..3). cnt increments every cycle. At cnt==REFRESH_DIV-1, cnt wraps to 0 and idx advances 0->1->2->3->0.
- REQ-013 SHALL capture all four segment inputs into a frame snapshot when idx==3 and cnt==REFRESH_DIV-1. It SHALL also capture them on the first clock edge after reset release. Input changes mid-frame SHALL NOT appear until the next frame.
- REQ-014 SHALL register seg, an and colon: each output reflects idx, cnt and display_en of the previous cycle (1-cycle latency).
- REQ-015 SHALL drive an=4'b1111 with seg blank when cnt<BLANK_CYCLES. Otherwise it SHALL drive exactly one an bit low (bit idx) and seg = snapshot[idx], inverted when SEG_ACTIVE_LOW=1.
- REQ-016 Blank seg value SHALL be 7'h7F when SEG_ACTIVE_LOW=1 and 7'h00 when SEG_ACTIVE_LOW=0.
- REQ-017 SHALL, when display_en==0, drive an=4'b1111, seg blank and colon=0. cnt and idx SHALL keep running, so re-enabling resumes at the current idx and cnt.
- REQ-018 SHALL never drive more than one an bit low in any cycle, including at wrap-around and across display_en transitions.
- REQ-019 sec_tick coinciding with a slot or frame boundary SHALL affect only colon state, never scan timing.

Reset
- REQ-020 SHALL, while reset_n==0 (asynchronously), force cnt=0, idx=0, snapshot=0, an=4'b1111, seg=blank, colon=0 and blink phase=0.
- REQ-021 SHALL restart scanning at idx=0, cnt=0 on the first edge after reset_n rises, including when reset occurs mid-slot or mid-frame.

Configuration
- REQ-022 Macro COLON_BLINK_EN: when defined, blink phase SHALL toggle on each sec_tick while display_en==1, and colon SHALL equal blink phase one cycle later. Blink phase SHALL hold while display_en==0.
- REQ-023 When COLON_BLINK_EN is not defined, colon SHALL equal display_en delayed one cycle, sec_tick SHALL be ignored, and no blink-phase register SHALL exist.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1, SEG_ACTIVE_LOW=1)
- REQ-024 Setup: release reset; minuteDisp1=7'h3F, minuteDisp2=7'h06, hourDisp1=7'h5B, hourDisp2=7'h4F; display_en=1. Required: an repeats {1111 x1, 1110 x3, 1111 x1, 1101 x3, 1111 x1, 1011 x3, 1111 x1, 0111 x3}, with seg = 7'h40, 7'h79, 7'h24, 7'h30 in the respective lit slots.
- REQ-025 Setup: change hourDisp2 to 7'h66 while idx==1. Required: digit 3 shows 7'h30 in the current frame and 7'h19 in the next frame.
- REQ-026 Setup: drop display_en during idx==2, hold 5 cycles, then raise it. Required: one cycle after the drop, an=1111, seg=7'h7F and colon=0; after raising, scan resumes at the running idx with no double-lit cycle.
- REQ-027 Setup: COLON_BLINK_EN defined; three sec_tick pulses 10 cycles apart. Required: colon goes 1, 0, 1, each change one cycle after its tick. Without the macro, colon stays 1 throughout.
- REQ-028 Setup: assert reset_n=0 mid-slot at idx=2, cnt=2. Required: without waiting for a clock edge, an=1111, seg=7'h7F and colon=0; after release, the first lit slot is an=1110.
